clk_divider_multi: RTL and testbench
====================================

Name: clk_divider_multi

Overview:
Parametrised multi-channel successor to the team's single fixed-ratio clock divider. It provides NUM_CH independent divided-clock outputs from one input clock. Each channel has a runtime-programmable ratio, a glitch-free ratio update at the period boundary, a per-channel enable with clean stop, a one-cycle tick strobe, and a global sync that phase-aligns all running channels. It sits at the clock/timing layer and feeds baud generators, sample strobes and slow peripheral clocks.

Parameters:
NUM_CH, 4, number of independent divider channels (≥1)
CNT_W, 8, width of the divide ratio and the internal counter
DEFAULT_DIV, 5, ratio loaded into every channel at reset (2 ≤ DEFAULT_DIV ≤ 2^CNT_W-1)

Ports:
clk_in  input  1  single system clock; all logic on its rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset), released synchronously by upstream reset logic
en  input  NUM_CH  per-channel run enable
div_in  input  NUM_CH x CNT_W  requested ratio per channel
div_load  input  NUM_CH  one-cycle strobe capturing div_in[i] into channel i's shadow register
sync  input  1  one-cycle strobe restarting all running channels in phase
clk_out  output  NUM_CH  divided clock per channel, registered
tick  output  NUM_CH  one-cycle pulse coincident with each clk_out rising edge
div_cur  output  NUM_CH x CNT_W  ratio currently in effect per channel

Behaviour:
- Reset (rst=0, asynchronous): clk_out=0, tick=0, cnt=0, div_cur=DEFAULT_DIV, shadow pending=0, state=IDLE for all channels. Reset asserted mid-operation clears immediately, with no period completion.
- Ratio clamp: any captured value of 0 or 1 is stored as 2. The legal range is 2..2^CNT_W-1.
- High time H = ceil(D/2); low time D-H. Even D gives 50% duty. Odd D is high for one extra cycle (D=5: 3 high, 2 low).
- Per-channel FSM states: IDLE, RUN, STOPPING.
  - IDLE: clk_out=0. When en[i]=1 sampled, the next edge goes to RUN with cnt<=0, clk_out<=1, tick<=1. First rising edge latency: 1 cycle after en is sampled high.
  - RUN: each edge cnt_next = (cnt==D-1) ? 0 : cnt+1; clk_out<=(cnt_next<H); tick<=(cnt_next==0). If en[i]=0 is sampled, go to STOPPING.
  - STOPPING: keep counting. At the boundary (cnt==D-1), go to IDLE instead of wrapping; clk_out stays 0 and tick stays 0. No truncated pulses are ever produced. If en[i] returns to 1 before the boundary, go back to RUN seamlessly.
- Ratio update:
  - div_load[i] writes the clamped div_in[i] to the shadow register and sets pending. A later load before the boundary overwrites the shadow (latest wins).
  - At the next period boundary (cnt==D-1 in RUN), or at sync, div_cur<=shadow, pending clears, and the new period starts at cnt=0 with the new D.
  - In IDLE, a load applies to div_cur on the next edge.
  - A load and a boundary on the same edge: the boundary uses the old shadow/pending state; the new value becomes pending for the following boundary.
- sync:
  - For every channel in RUN or STOPPING, the next edge sets cnt<=0, clk_out<=1, tick<=1 and applies any pending ratio. A STOPPING channel returns to RUN only if en[i]=1.
  - IDLE channels ignore sync.
  - sync takes priority over the boundary and the stop decision on the same edge.
- Channels are fully independent except for sync. Counter arithmetic is unsigned CNT_W-bit; the cnt==D-1 compare prevents overflow.

Decomposition:
- Package clk_div_pkg contains:
  - ch_state_t enum {IDLE, RUN, STOPPING}
  - function clamp_div(value) returning max(value, 2)
  - function high_time(D) returning (D+1)>>1
- Sub-module clk_div_channel: one channel's FSM, counter, shadow register and outputs, parametrised by CNT_W and DEFAULT_DIV.
- The top level is a generate loop over NUM_CH plus fan-out of sync.

Test Plan:
- Reset release with en=4'b0001, DEFAULT_DIV=5 -> ch0 clk_out high 3 cycles / low 2, repeating; tick once per 5 cycles; other channels stay 0; div_cur=5 on all.
- RUN at D=5, div_load ch0 with div_in=4 mid-period -> current 5-cycle period completes, then 2 high / 2 low; div_cur changes to 4 exactly at the boundary.
- Two loads (6, then 8) within one period -> only 8 takes effect; div_in=0 or 1 -> div_cur=2, 1 high / 1 low.
- en[0] dropped during the high phase at D=6 -> remaining high and low cycles of the period complete, then clk_out held 0 with no extra tick; en re-raised 2 cycles later -> clk_out high on the next edge.
- ch0 D=4, ch1 D=6 running out of phase, sync pulse -> both clk_out=1 and tick=1 on the same edge; ch1 pending ratio 3 applied at that edge.
- rst driven low mid-period -> all outputs 0 immediately (asynchronous); after release, div_cur=DEFAULT_DIV and the previously pending ratio is discarded.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} ch_state_t;

  // Ratios below 2 cannot produce a high and a low phase, so they are raised to 2.
  function automatic int unsigned clamp_div(int unsigned value);
    return (value < 32'd2) ? 32'd2 : value;
  endfunction

  function automatic int unsigned high_time(int unsigned d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: FSM, period counter, shadow ratio register and registered outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur
);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] next_div;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_cnt;
  logic             at_boundary;

  assign load_val    = CNT_W'(clamp_div(32'(div_in)));
  assign next_div    = pending_q ? shadow_q : div_q;
  assign cnt_inc     = cnt_q + 1'b1;
  assign high_cnt    = CNT_W'(high_time(32'(div_q)));
  assign at_boundary = (cnt_q == div_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_d     = 1'b0;
        div_d     = div_load ? load_val : next_div;
        pending_d = 1'b0;
        if (en) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN, STOPPING: begin
        // A stopping channel whose enable came back wraps like a running one.
        if (sync || (at_boundary && (state_q == RUN || en))) begin
          cnt_d     = '0;
          clk_d     = 1'b1;
          tick_d    = 1'b1;
          div_d     = next_div;
          pending_d = 1'b0;
          if (sync) state_d = (state_q == STOPPING && !en) ? STOPPING : RUN;
          else      state_d = en ? RUN : STOPPING;
        end else if (at_boundary) begin
          state_d   = IDLE;
          cnt_d     = '0;
          clk_d     = 1'b0;
          div_d     = next_div;
          pending_d = 1'b0;
        end else begin
          cnt_d   = cnt_inc;
          clk_d   = (cnt_inc < high_cnt);
          state_d = en ? RUN : STOPPING;
        end
        // Applied after the boundary so a same-edge load waits for the next one.
        if (div_load) begin
          shadow_d  = load_val;
          pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      shadow_q  <= CNT_W'(DEFAULT_DIV);
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign div_cur = div_q;

endmodule

// File: rtl/clk_divider_multi.sv
// NUM_CH independent programmable clock dividers sharing one clock and a global sync strobe.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            en,
  input  logic [NUM_CH-1:0][CNT_W-1:0] div_in,
  input  logic [NUM_CH-1:0]            div_load,
  input  logic                         sync,
  output logic [NUM_CH-1:0]            clk_out,
  output logic [NUM_CH-1:0]            tick,
  output logic [NUM_CH-1:0][CNT_W-1:0] div_cur
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en[i]),
      .div_in  (div_in[i]),
      .div_load(div_load[i]),
      .sync    (sync),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .div_cur (div_cur[i])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi with hand-computed waveforms per scenario.
module tb_clk_divider_multi;

  logic            clk_in = 1'b0;
  logic            rst    = 1'b0;
  logic [3:0]      en;
  logic [3:0][7:0] div_in;
  logic [3:0]      div_load;
  logic            sync;
  logic [3:0]      clk_out;
  logic [3:0]      tick;
  logic [3:0][7:0] div_cur;

  int n_vec = 0;
  int n_err = 0;

  clk_divider_multi #(
    .NUM_CH     (4),
    .CNT_W      (8),
    .DEFAULT_DIV(5)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .div_in  (div_in),
    .div_load(div_load),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = '0; div_load = '0; sync = 1'b0; div_in = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] pc, pt;
    do_reset();
    n_vec++;
    if (clk_out !== 4'b0000) begin
      n_err++; $display("FAIL reset_clk_out: got %b expected 0000", clk_out);
    end
    n_vec++;
    if (tick !== 4'b0000) begin
      n_err++; $display("FAIL reset_tick: got %b expected 0000", tick);
    end
    n_vec++;
    if (div_cur !== {4{8'd5}}) begin
      n_err++; $display("FAIL reset_div_cur: got %h expected 05050505", div_cur);
    end
    pc = 10'b0011100111;
    pt = 10'b0000100001;
    en = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (clk_out !== {3'b000, pc[i]}) begin
        n_err++; $display("FAIL d5_clk_out[%0d]: got %b expected %b", i, clk_out, {3'b000, pc[i]});
      end
      n_vec++;
      if (tick !== {3'b000, pt[i]}) begin
        n_err++; $display("FAIL d5_tick[%0d]: got %b expected %b", i, tick, {3'b000, pt[i]});
      end
    end
    n_vec++;
    if (div_cur !== {4{8'd5}}) begin
      n_err++; $display("FAIL d5_div_cur: got %h expected 05050505", div_cur);
    end
  endtask

  task automatic test_load_mid();
    logic [7:0] pc, pt;
    logic [7:0] exp_div;
    do_reset();
    en = 4'b0001;
    step();
    step();
    div_in[0] = 8'd4;
    div_load  = 4'b0001;
    pc = 8'b10011001;
    pt = 8'b10001000;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) div_load = '0;
      exp_div = (i >= 3) ? 8'd4 : 8'd5;
      n_vec++;
      if (clk_out[0] !== pc[i]) begin
        n_err++; $display("FAIL load_clk[%0d]: got %b expected %b", i, clk_out[0], pc[i]);
      end
      n_vec++;
      if (tick[0] !== pt[i]) begin
        n_err++; $display("FAIL load_tick[%0d]: got %b expected %b", i, tick[0], pt[i]);
      end
      n_vec++;
      if (div_cur[0] !== exp_div) begin
        n_err++; $display("FAIL load_div[%0d]: got %0d expected %0d", i, div_cur[0], exp_div);
      end
    end
  endtask

  task automatic test_latest_wins_clamp();
    do_reset();
    en = 4'b0001;
    step();
    div_in[0] = 8'd6; div_load = 4'b0001;
    step();
    div_in[0] = 8'd8;
    step();
    div_load = '0;
    step();
    step();
    n_vec++;
    if (div_cur[0] !== 8'd5) begin
      n_err++; $display("FAIL latest_pre: got %0d expected 5", div_cur[0]);
    end
    step();
    n_vec++;
    if (div_cur[0] !== 8'd8) begin
      n_err++; $display("FAIL latest_wins: got %0d expected 8", div_cur[0]);
    end
    n_vec++;
    if ({clk_out[0], tick[0]} !== 2'b11) begin
      n_err++; $display("FAIL latest_edge: got %b expected 11", {clk_out[0], tick[0]});
    end
    div_in[0] = 8'd0; div_load = 4'b0001;
    step();
    div_load = '0;
    repeat (6) step();
    n_vec++;
    if ({div_cur[0], clk_out[0]} !== {8'd8, 1'b0}) begin
      n_err++; $display("FAIL clamp_pre: got div %0d clk %b expected div 8 clk 0",
                        div_cur[0], clk_out[0]);
    end
    step();
    n_vec++;
    if ({div_cur[0], clk_out[0], tick[0]} !== {8'd2, 2'b11}) begin
      n_err++; $display("FAIL clamp0_apply: got div %0d clk %b tick %b expected div 2 clk 1 tick 1",
                        div_cur[0], clk_out[0], tick[0]);
    end
    step();
    n_vec++;
    if ({clk_out[0], tick[0]} !== 2'b00) begin
      n_err++; $display("FAIL clamp0_low: got %b expected 00", {clk_out[0], tick[0]});
    end
    step();
    n_vec++;
    if ({clk_out[0], tick[0]} !== 2'b11) begin
      n_err++; $display("FAIL clamp0_high: got %b expected 11", {clk_out[0], tick[0]});
    end
    div_in[1] = 8'd1; div_load = 4'b0010;
    step();
    div_load = '0;
    n_vec++;
    if (div_cur[1] !== 8'd2) begin
      n_err++; $display("FAIL clamp1_idle: got %0d expected 2", div_cur[1]);
    end
  endtask

  task automatic test_stop();
    do_reset();
    div_in[0] = 8'd6; div_load = 4'b0001;
    step();
    div_load = '0;
    n_vec++;
    if (div_cur[0] !== 8'd6) begin
      n_err++; $display("FAIL stop_idle_load: got %0d expected 6", div_cur[0]);
    end
    en = 4'b0001;
    step();
    n_vec++;
    if ({clk_out[0], tick[0]} !== 2'b11) begin
      n_err++; $display("FAIL stop_first_edge: got %b expected 11", {clk_out[0], tick[0]});
    end
    step();
    en = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step();
      n_vec++;
      if ({clk_out[0], tick[0]} !== {(i == 0), 1'b0}) begin
        n_err++; $display("FAIL stop_drain[%0d]: got %b expected %b", i,
                          {clk_out[0], tick[0]}, {(i == 0), 1'b0});
      end
    end
    en = 4'b0001;
    step();
    n_vec++;
    if ({clk_out[0], tick[0]} !== 2'b11) begin
      n_err++; $display("FAIL stop_restart: got %b expected 11", {clk_out[0], tick[0]});
    end
  endtask

  task automatic test_sync();
    do_reset();
    div_in[0] = 8'd4; div_in[1] = 8'd6; div_load = 4'b0011;
    step();
    div_load = '0;
    n_vec++;
    if ({div_cur[1], div_cur[0]} !== {8'd6, 8'd4}) begin
      n_err++; $display("FAIL sync_setup: got %h expected 0604", {div_cur[1], div_cur[0]});
    end
    en = 4'b0001;
    step();
    step();
    en = 4'b0011;
    step();
    step();
    div_in[1] = 8'd3; div_load = 4'b0010;
    step();
    div_load = '0;
    n_vec++;
    if (div_cur[1] !== 8'd6) begin
      n_err++; $display("FAIL sync_pending: got %0d expected 6", div_cur[1]);
    end
    step();
    n_vec++;
    if ({clk_out[1:0], tick[1:0]} !== 4'b0100) begin
      n_err++; $display("FAIL sync_pre: got %b expected 0100", {clk_out[1:0], tick[1:0]});
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    n_vec++;
    if ({clk_out[1:0], tick[1:0]} !== 4'b1111) begin
      n_err++; $display("FAIL sync_align: got %b expected 1111", {clk_out[1:0], tick[1:0]});
    end
    n_vec++;
    if ({div_cur[1], div_cur[0]} !== {8'd3, 8'd4}) begin
      n_err++; $display("FAIL sync_ratio: got %h expected 0304", {div_cur[1], div_cur[0]});
    end
    step();
    step();
    step();
    n_vec++;
    if ({clk_out[1:0], tick[1:0]} !== 4'b1010) begin
      n_err++; $display("FAIL sync_after: got %b expected 1010", {clk_out[1:0], tick[1:0]});
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] pc, pt;
    do_reset();
    en = 4'b0001;
    step();
    step();
    div_in[0] = 8'd7; div_load = 4'b0001;
    step();
    div_load = '0;
    n_vec++;
    if (clk_out[0] !== 1'b1) begin
      n_err++; $display("FAIL arst_pre: got %b expected 1", clk_out[0]);
    end
    rst = 1'b0;
    #2;
    n_vec++;
    if ({clk_out, tick} !== 8'h00) begin
      n_err++; $display("FAIL arst_immediate: got %h expected 00", {clk_out, tick});
    end
    n_vec++;
    if (div_cur !== {4{8'd5}}) begin
      n_err++; $display("FAIL arst_div: got %h expected 05050505", div_cur);
    end
    step();
    step();
    rst = 1'b1;
    pc = 6'b100111;
    pt = 6'b100001;
    for (int i = 0; i < 6; i++) begin
      step();
      n_vec++;
      if ({clk_out[0], tick[0], div_cur[0]} !== {pc[i], pt[i], 8'd5}) begin
        n_err++; $display("FAIL arst_resume[%0d]: got clk %b tick %b div %0d expected clk %b tick %b div 5",
                          i, clk_out[0], tick[0], div_cur[0], pc[i], pt[i]);
      end
    end
  endtask

  initial begin
    en = '0; div_in = '0; div_load = '0; sync = 1'b0;
    test_reset();
    test_load_mid();
    test_latest_wins_clamp();
    test_stop();
    test_sync();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
